// File: rtl/adder_operand_feeder_pkg.sv
// Shared definitions for the operand feeder: issue FSM encodings and a
// constant-foldable ceiling log2 used to size pointers and the level port.
package adder_operand_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } feeder_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/operand_pair_fifo.sv
// Synchronous FIFO for operand pairs. Pointers carry one extra wrap bit so
// full and empty are distinguished without a separate counter compare.
module operand_pair_fifo
    import adder_operand_feeder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] level
);

    localparam int          AW       = clog2(DEPTH);
    localparam logic [AW:0] PTR_ZERO = {(AW + 1){1'b0}};
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      level_r;
    logic             push_en_s;
    logic             pop_en_s;

    // Status flags and qualified push/pop; flush overrides both
    always_comb begin
        full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        empty     = (wr_ptr_r == rd_ptr_r);
        push_en_s = push && !full && !flush;
        pop_en_s  = pop && !empty && !flush;
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= PTR_ZERO;
        end else begin
            if (push_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_en_s, pop_en_s})
                2'b10:   level_r <= level_r + PTR_ONE;
                2'b01:   level_r <= level_r - PTR_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Pair storage; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (push_en_s && !rst) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r[AW-1:0]];
    assign level = level_r;

endmodule

// File: rtl/adder_operand_feeder.sv
// Feeds buffered operand pairs to the registered adder one at a time,
// pacing issue with the adder's busy flag.
module adder_operand_feeder
    import adder_operand_feeder_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DWIDTH-1:0]     s_in1,
    input  logic [DWIDTH-1:0]     s_in2,
    input  logic                  flush,
    input  logic                  busy,
    output logic [DWIDTH-1:0]     in1,
    output logic [DWIDTH-1:0]     in2,
    output logic                  ivalid,
    output logic [clog2(DEPTH):0] level
);

    feeder_state_e       state_r;
    feeder_state_e       state_next_s;
    logic                wait_first_r;
    logic                pop_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [2*DWIDTH-1:0] head_s;
    logic [DWIDTH-1:0]   in1_r;
    logic [DWIDTH-1:0]   in2_r;
    logic                ivalid_r;

    operand_pair_fifo #(
        .WIDTH (2 * DWIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid),
        .pop   (pop_s),
        .flush (flush),
        .wdata ({s_in1, s_in2}),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (level)
    );

    assign s_ready = !fifo_full_s;

    // Next state and pop decision; busy is not trusted in the first WAIT cycle
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s && !busy && !flush) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (!wait_first_r && !busy) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register plus first-WAIT-cycle marker
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            wait_first_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            wait_first_r <= (state_r == ST_ISSUE);
        end
    end

    // Issue registers; operands hold between issues
    always_ff @(posedge clk) begin
        if (rst) begin
            ivalid_r <= 1'b0;
            in1_r    <= {DWIDTH{1'b0}};
            in2_r    <= {DWIDTH{1'b0}};
        end else begin
            ivalid_r <= pop_s;
            if (pop_s) begin
                in1_r <= head_s[2*DWIDTH-1:DWIDTH];
                in2_r <= head_s[DWIDTH-1:0];
            end
        end
    end

    assign in1    = in1_r;
    assign in2    = in2_r;
    assign ivalid = ivalid_r;

endmodule

// File: tb/tb_adder_operand_feeder.sv
// Self-checking bench: directed scenarios plus random traffic, scored
// against a queue model of accepted pairs and the issue pacing rules.
module tb_adder_operand_feeder;

    localparam int DWIDTH = 8;
    localparam int DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_in1;
    logic [7:0] s_in2;
    logic       flush;
    logic       busy;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       ivalid;
    logic [2:0] level;

    always #5 clk = ~clk;

    adder_operand_feeder #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_in1   (s_in1),
        .s_in2   (s_in2),
        .flush   (flush),
        .busy    (busy),
        .in1     (in1),
        .in2     (in2),
        .ivalid  (ivalid),
        .level   (level)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] pair_q [$];
    logic [7:0]  exp_in1 = 8'h00;
    logic [7:0]  exp_in2 = 8'h00;
    int          last_issue = -100;
    int          stall_cnt = 0;
    int          issue_total = 0;
    bit          resp_en = 1'b0;
    int          resp_len_cfg = 0;
    int          busy_left = 0;
    logic        ivalid_prev = 1'b0;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: capture inputs, advance, update the model and compare.
    task automatic step();
        logic        p_rst;
        logic        p_valid;
        logic        p_flush;
        logic        p_busy;
        logic [15:0] p_pair;
        logic [15:0] head;
        int          p_size;
        p_rst   = rst;
        p_valid = s_valid;
        p_flush = flush;
        p_busy  = busy;
        p_pair  = {s_in1, s_in2};
        p_size  = pair_q.size();
        @(posedge clk);
        #1;
        cyc++;
        if (p_rst) begin
            pair_q.delete();
            exp_in1    = 8'h00;
            exp_in2    = 8'h00;
            last_issue = -100;
            stall_cnt  = 0;
            busy_left  = 0;
            check_val("rst_ivalid", int'(ivalid), 0);
            check_val("rst_level", int'(level), 0);
            check_val("rst_in1", int'(in1), 0);
            check_val("rst_in2", int'(in2), 0);
        end else begin
            if (ivalid) begin
                issue_total++;
                check_val("issue_nonempty", int'(p_size != 0), 1);
                check_val("issue_while_busy", int'(p_busy), 0);
                check_val("issue_on_flush", int'(p_flush), 0);
                check_val("issue_gap", int'((cyc - last_issue) >= 3), 1);
                last_issue = cyc;
                stall_cnt  = 0;
                if (p_size != 0) begin
                    head    = pair_q.pop_front();
                    exp_in1 = head[15:8];
                    exp_in2 = head[7:0];
                end
                check_val("issue_in1", int'(in1), int'(exp_in1));
                check_val("issue_in2", int'(in2), int'(exp_in2));
            end else begin
                check_val("hold_in1", int'(in1), int'(exp_in1));
                check_val("hold_in2", int'(in2), int'(exp_in2));
                if (p_size != 0 && !p_busy && !p_flush) begin
                    stall_cnt++;
                end else begin
                    stall_cnt = 0;
                end
                check_val("issue_stall", int'(stall_cnt > 4), 0);
            end
            if (p_flush) begin
                pair_q.delete();
            end else if (p_valid && p_size < DEPTH) begin
                pair_q.push_back(p_pair);
            end
            check_val("level", int'(level), pair_q.size());
            check_val("s_ready", int'(s_ready), int'(pair_q.size() < DEPTH));
        end
        if (resp_en) begin
            if (ivalid_prev) begin
                busy_left = (resp_len_cfg > 0) ? resp_len_cfg : int'($urandom_range(3, 1));
            end
            if (busy_left > 0) begin
                busy = 1'b1;
                busy_left--;
            end else begin
                busy = 1'b0;
            end
        end
        ivalid_prev = ivalid;
    endtask

    initial begin
        int  base;
        bit  found;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_in1   = 8'h00;
        s_in2   = 8'h00;
        flush   = 1'b0;
        busy    = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        check_val("reset_s_ready", int'(s_ready), 1);
        check_val("reset_level", int'(level), 0);
        check_val("reset_ivalid", int'(ivalid), 0);
        step();

        // Single pair latency and one-cycle strobe
        s_valid = 1'b1;
        s_in1   = 8'h3C;
        s_in2   = 8'h0F;
        step();
        s_valid = 1'b0;
        check_val("t2_no_early", int'(ivalid), 0);
        step();
        check_val("t2_ivalid", int'(ivalid), 1);
        check_val("t2_in1", int'(in1), 32'h3C);
        check_val("t2_in2", int'(in2), 32'h0F);
        step();
        check_val("t2_pulse_end", int'(ivalid), 0);
        repeat (4) step();

        // Reset held two cycles during an issue
        s_valid = 1'b1;
        s_in1   = 8'hA5;
        s_in2   = 8'h5A;
        step();
        s_in1 = 8'h11;
        s_in2 = 8'h22;
        step();
        s_valid = 1'b0;
        check_val("t1_issue", int'(ivalid), 1);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        check_val("t1_ivalid", int'(ivalid), 0);
        check_val("t1_level", int'(level), 0);
        check_val("t1_s_ready", int'(s_ready), 1);
        check_val("t1_in1", int'(in1), 0);
        check_val("t1_in2", int'(in2), 0);
        repeat (5) step();

        // Back-pressure: five pushes while busy, only four fit
        busy    = 1'b1;
        s_valid = 1'b1;
        base    = issue_total;
        for (int i = 0; i < 5; i++) begin
            s_in1 = 8'($urandom);
            s_in2 = 8'($urandom);
            step();
            if (i == 3) begin
                check_val("t3_ready_low", int'(s_ready), 0);
            end
        end
        s_valid = 1'b0;
        check_val("t3_level", int'(level), 4);
        check_val("t3_no_issue", issue_total - base, 0);
        busy         = 1'b0;
        resp_en      = 1'b1;
        resp_len_cfg = 0;
        for (int i = 0; i < 40 && (issue_total - base) < 4; i++) begin
            step();
        end
        check_val("t3_drained", issue_total - base, 4);

        // Adder holding busy for three cycles per operation
        resp_len_cfg = 3;
        s_valid      = 1'b1;
        base         = issue_total;
        for (int i = 0; i < 3; i++) begin
            s_in1 = 8'($urandom);
            s_in2 = 8'($urandom);
            step();
        end
        s_valid = 1'b0;
        for (int i = 0; i < 60 && (issue_total - base) < 3; i++) begin
            step();
        end
        check_val("t4_issues", issue_total - base, 3);
        repeat (8) step();
        resp_en   = 1'b0;
        busy      = 1'b0;
        busy_left = 0;
        repeat (6) step();

        // Flush during WAIT with a concurrent push
        busy    = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_in1 = 8'(8'h40 + i);
            s_in2 = 8'(8'h80 + i);
            step();
        end
        s_valid = 1'b0;
        busy    = 1'b0;
        step();
        check_val("t6_issue", int'(ivalid), 1);
        step();
        check_val("t6_level3", int'(level), 3);
        flush   = 1'b1;
        s_valid = 1'b1;
        s_in1   = 8'hEE;
        s_in2   = 8'hDD;
        step();
        flush   = 1'b0;
        s_valid = 1'b0;
        check_val("t6_level0", int'(level), 0);
        base = issue_total;
        repeat (10) step();
        check_val("t6_no_issue", issue_total - base, 0);

        // Push and pop on the same edge, then pop from full
        busy    = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_in1 = 8'($urandom);
            s_in2 = 8'($urandom);
            step();
        end
        busy  = 1'b0;
        s_in1 = 8'h77;
        s_in2 = 8'h99;
        step();
        check_val("t5_pop", int'(ivalid), 1);
        check_val("t5_level2", int'(level), 2);
        busy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_in1 = 8'($urandom);
            s_in2 = 8'($urandom);
            step();
        end
        s_valid = 1'b0;
        check_val("t5_full", int'(s_ready), 0);
        busy  = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step();
            found = ivalid;
        end
        check_val("t5_pop_seen", int'(found), 1);
        check_val("t5_ready_back", int'(s_ready), 1);
        check_val("t5_level3", int'(level), 3);
        resp_en      = 1'b1;
        resp_len_cfg = 0;
        repeat (20) step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            s_valid = (($urandom % 4) != 0);
            s_in1   = 8'($urandom);
            s_in2   = 8'($urandom);
            flush   = (($urandom % 40) == 0);
            rst     = (($urandom % 150) == 0);
            step();
        end
        s_valid = 1'b0;
        flush   = 1'b0;
        rst     = 1'b0;
        repeat (40) step();
        check_val("final_empty", int'(level), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
